// File: rtl/des_round_if.sv
// Handshake and f-function bus between the DES round sequencer and its surroundings.
// The slave modport is the controller's view; master is the feeder/consumer view.
interface des_round_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [55:0] in_key;
    logic        in_decrypt;
    logic [31:0] f_r;
    logic [55:0] f_cd;
    logic [31:0] f_in;
    logic [3:0]  round_idx;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, f_in, out_ready,
        output in_ready, f_r, f_cd, round_idx, busy, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_key, in_decrypt, f_in, out_ready,
        input  in_ready, f_r, f_cd, round_idx, busy, out_valid, out_data
    );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: one Feistel round per clock over L/R, with the
// C/D key-schedule halves rotated in place for encrypt or decrypt order.
module des_round_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    des_round_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [4:0] ROUNDS_W   = 5'(ROUNDS);

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic [3:0]  round_q, round_d;

    // Key-schedule rotation amount for schedule position 1..16.
    function automatic logic [1:0] shift_amt(input logic [4:0] idx);
        logic [1:0] amt;
        case (idx)
            5'd1, 5'd2, 5'd9, 5'd16:                  amt = 2'd1;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: amt = 2'd2;
            default:                                  amt = 2'd0;
        endcase
        return amt;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        case (n)
            2'd1:    y = {x[26:0], x[27]};
            2'd2:    y = {x[25:0], x[27:26]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        case (n)
            2'd1:    y = {x[0], x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= 32'd0;
            r_q     <= 32'd0;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            dec_q   <= 1'b0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            round_q <= round_d;
        end
    end

    // Next-state and datapath update for load, round iteration and output hold.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    l_d     = bus.in_data[63:32];
                    r_d     = bus.in_data[31:0];
                    dec_d   = bus.in_decrypt;
                    round_d = 4'd0;
                    state_d = ROUND;
                    // Decrypt starts from K16, which equals the unrotated key.
                    if (bus.in_decrypt) begin
                        c_d = bus.in_key[55:28];
                        d_d = bus.in_key[27:0];
                    end else begin
                        c_d = rotl28(bus.in_key[55:28], shift_amt(5'd1));
                        d_d = rotl28(bus.in_key[27:0], shift_amt(5'd1));
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                l_d = r_q;
                r_d = l_q ^ bus.f_in;
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    if (dec_q) begin
                        c_d = rotr28(c_q, shift_amt(ROUNDS_W - {1'b0, round_q}));
                        d_d = rotr28(d_q, shift_amt(ROUNDS_W - {1'b0, round_q}));
                    end else begin
                        c_d = rotl28(c_q, shift_amt({1'b0, round_q} + 5'd2));
                        d_d = rotl28(d_q, shift_amt({1'b0, round_q} + 5'd2));
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == ROUND);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = {r_q, l_q};
    assign bus.f_r       = r_q;
    assign bus.f_cd      = {c_q, d_q};
    assign bus.round_idx = round_q;
endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: surrounds the sequencer with a software DES
// (IP/PC-1/PC-2/E/S/P/FP) and compares against a whole-cipher reference.
module tb_des_round_ctrl;
    logic clk;
    logic rst_n;
    bit   use_f;
    int   n_checks;
    int   n_pass;

    des_round_if bus ();

    des_round_ctrl #(.ROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ip_t[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int e_t[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] sbox[8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Table permutation, DES bit numbering (bit 1 = MSB of the in_w-bit input).
    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int tbl[$]);
        logic [63:0] o;
        o = 64'd0;
        for (int j = 0; j < tbl.size(); j++) o = {o[62:0], x[in_w - tbl[j]]};
        return o;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {x, x} << (n % 28);
        return t[55:28];
    endfunction

    function automatic logic [63:0] ip_of(input logic [63:0] x);
        return perm(x, 64, ip_t);
    endfunction
    function automatic logic [63:0] fp_of(input logic [63:0] x);
        return perm(x, 64, fp_t);
    endfunction
    function automatic logic [55:0] pc1_of(input logic [63:0] k);
        logic [63:0] t;
        t = perm(k, 64, pc1_t);
        return t[55:0];
    endfunction
    function automatic logic [47:0] pc2_of(input logic [55:0] cd);
        logic [63:0] t;
        t = perm({8'd0, cd}, 56, pc2_t);
        return t[47:0];
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [63:0]  e;
        logic [47:0]  x;
        logic [31:0]  s;
        logic [5:0]   c;
        logic [255:0] sb;
        logic [63:0]  p;
        int           idx;
        e = perm({32'd0, r}, 32, e_t);
        x = e[47:0] ^ k;
        s = 32'd0;
        for (int i = 0; i < 8; i++) begin
            c   = x[47 - 6 * i -: 6];
            idx = int'({c[5], c[0]}) * 16 + int'(c[4:1]);
            sb  = sbox[i];
            s   = {s[27:0], sb[255 - 4 * idx -: 4]};
        end
        p = perm({32'd0, s}, 32, p_t);
        return p[31:0];
    endfunction

    // Whole-cipher reference: all 16 subkeys from cumulative rotations, then 16 rounds.
    function automatic logic [63:0] ref_des(input logic [63:0] blk, input logic [63:0] key, input bit dec);
        logic [55:0] cd;
        logic [47:0] ks[16];
        logic [63:0] t;
        logic [31:0] l, r, tmp;
        int          sh;
        cd = pc1_of(key);
        sh = 0;
        for (int i = 0; i < 16; i++) begin
            sh    += shifts[i];
            ks[i] = pc2_of({rot28(cd[55:28], sh), rot28(cd[27:0], sh)});
        end
        t = ip_of(blk);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r   = l ^ des_f(r, ks[dec ? 15 - i : i]);
            l   = tmp;
        end
        return fp_of({r, l});
    endfunction

    // Expected {C,D} presented during round i.
    function automatic logic [55:0] exp_cd(input logic [55:0] cd, input bit dec, input int i);
        int sh;
        sh = 0;
        if (dec) begin
            for (int j = 16 - i; j < 16; j++) sh += shifts[j];
            sh = 28 - (sh % 28);
        end else begin
            for (int j = 0; j <= i; j++) sh += shifts[j];
        end
        return {rot28(cd[55:28], sh), rot28(cd[27:0], sh)};
    endfunction

    assign bus.f_in = use_f ? des_f(bus.f_r, pc2_of(bus.f_cd)) : 32'd0;

    logic [63:0] rb_out;
    int          rb_lat;
    int          rb_ctl_err;
    logic [55:0] rb_cd[16];
    logic [3:0]  rb_idx[16];
    logic [55:0] rb_done_cd;

    // Offer one block, record per-round observations, and collect the result.
    task automatic run_block(input logic [63:0] din, input logic [55:0] kin, input bit dec);
        int n;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_data    = din;
        bus.in_key     = kin;
        bus.in_decrypt = dec;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_data    = 64'($urandom) << 32 | 64'($urandom);
        bus.in_key     = 56'($urandom) << 28;
        bus.in_decrypt = ~dec;
        rb_lat     = 1;
        rb_ctl_err = 0;
        while (bus.out_valid !== 1'b1 && rb_lat < 40) begin
            if (rb_lat <= 16) begin
                rb_cd[rb_lat - 1]  = bus.f_cd;
                rb_idx[rb_lat - 1] = bus.round_idx;
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) rb_ctl_err++;
            end
            @(negedge clk);
            rb_lat++;
        end
        rb_out     = bus.out_data;
        rb_done_cd = bus.f_cd;
        if (bus.out_valid !== 1'b1) rb_lat = -1;
    endtask

    task automatic apply_reset();
        bus.in_valid   = 1'b0;
        bus.in_data    = 64'd0;
        bus.in_key     = 56'd0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.busy); else n_pass++;
        n_checks++; if (bus.round_idx !== 4'd0) $display("FAIL reset_round_idx: got %0d exp 0", bus.round_idx); else n_pass++;
        n_checks++; if (bus.out_data !== 64'd0) $display("FAIL reset_lr: got %h exp 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.f_cd !== 56'd0) $display("FAIL reset_cd: got %h exp 0", bus.f_cd); else n_pass++;
    endtask

    task automatic test_swap_path();
        use_f = 1'b0;
        run_block(64'h01234567_89ABCDEF, 56'($urandom), 1'b0);
        n_checks++; if (rb_out !== 64'h89ABCDEF_01234567) $display("FAIL swap_out: got %h exp 89abcdef01234567", rb_out); else n_pass++;
        n_checks++; if (rb_lat != 17) $display("FAIL swap_latency: got %0d exp 17", rb_lat); else n_pass++;
        n_checks++; if (rb_ctl_err != 0) $display("FAIL swap_busy_ready: got %0d bad cycles exp 0", rb_ctl_err); else n_pass++;
    endtask

    task automatic test_key_schedule();
        logic [55:0] k1;
        use_f = 1'b0;
        k1 = {28'h0000001, 28'h0000001};
        run_block($urandom, k1, 1'b0);
        n_checks++; if (rb_cd[0] !== {28'h0000002, 28'h0000002}) $display("FAIL enc_cd_r0: got %h exp 0000002_0000002", rb_cd[0]); else n_pass++;
        n_checks++; if (rb_cd[1] !== {28'h0000004, 28'h0000004}) $display("FAIL enc_cd_r1: got %h exp 0000004_0000004", rb_cd[1]); else n_pass++;
        n_checks++; if (rb_cd[2] !== {28'h0000010, 28'h0000010}) $display("FAIL enc_cd_r2: got %h exp 0000010_0000010", rb_cd[2]); else n_pass++;
        n_checks++; if (rb_done_cd !== k1) $display("FAIL enc_cd_done: got %h exp %h", rb_done_cd, k1); else n_pass++;
        run_block($urandom, k1, 1'b1);
        n_checks++; if (rb_cd[0] !== {28'h0000001, 28'h0000001}) $display("FAIL dec_cd_r0: got %h exp 0000001_0000001", rb_cd[0]); else n_pass++;
        n_checks++; if (rb_cd[1] !== {28'h8000000, 28'h8000000}) $display("FAIL dec_cd_r1: got %h exp 8000000_8000000", rb_cd[1]); else n_pass++;
        n_checks++; if (rb_cd[2] !== {28'h2000000, 28'h2000000}) $display("FAIL dec_cd_r2: got %h exp 2000000_2000000", rb_cd[2]); else n_pass++;
    endtask

    task automatic test_des_vector();
        logic [63:0] key, pt, ct;
        use_f = 1'b1;
        key = 64'h133457799BBCDFF1;
        pt  = 64'h0123456789ABCDEF;
        run_block(ip_of(pt), pc1_of(key), 1'b0);
        ct = fp_of(rb_out);
        n_checks++; if (ct !== 64'h85E813540F0AB405) $display("FAIL vec_encrypt: got %h exp 85e813540f0ab405", ct); else n_pass++;
        run_block(ip_of(64'h85E813540F0AB405), pc1_of(key), 1'b1);
        n_checks++; if (fp_of(rb_out) !== pt) $display("FAIL vec_decrypt: got %h exp %h", fp_of(rb_out), pt); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] key, pt, ct;
        bit          dec;
        int          cd_err, idx_err;
        use_f = 1'b1;
        for (int t = 0; t < 6; t++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            dec = 1'($urandom);
            run_block(ip_of(pt), pc1_of(key), dec);
            ct = fp_of(rb_out);
            n_checks++; if (ct !== ref_des(pt, key, dec)) $display("FAIL rand_block%0d: got %h exp %h", t, ct, ref_des(pt, key, dec)); else n_pass++;
            n_checks++; if (rb_lat != 17) $display("FAIL rand_latency%0d: got %0d exp 17", t, rb_lat); else n_pass++;
            cd_err  = 0;
            idx_err = 0;
            for (int i = 0; i < 16; i++) begin
                if (rb_cd[i] !== exp_cd(pc1_of(key), dec, i)) cd_err++;
                if (rb_idx[i] !== 4'(i)) idx_err++;
            end
            n_checks++; if (cd_err != 0) $display("FAIL rand_schedule%0d: got %0d wrong rounds exp 0", t, cd_err); else n_pass++;
            n_checks++; if (idx_err != 0) $display("FAIL rand_round_idx%0d: got %0d wrong rounds exp 0", t, idx_err); else n_pass++;
            run_block(ip_of(ct), pc1_of(key), ~dec);
            n_checks++; if (fp_of(rb_out) !== pt) $display("FAIL rand_roundtrip%0d: got %h exp %h", t, fp_of(rb_out), pt); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] key, pt, held, expv;
        int          n, unstable;
        use_f = 1'b1;
        key  = {$urandom, $urandom};
        pt   = {$urandom, $urandom};
        expv = ref_des(pt, key, 1'b0);
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = ip_of(pt);
        bus.in_key     = pc1_of(key);
        bus.in_decrypt = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b exp 1", bus.out_valid); else n_pass++;
        held = bus.out_data;
        n_checks++; if (fp_of(held) !== expv) $display("FAIL bp_result: got %h exp %h", fp_of(held), expv); else n_pass++;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_data !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) unstable++;
        end
        n_checks++; if (unstable != 0) $display("FAIL bp_hold: got %0d bad cycles exp 0", unstable); else n_pass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL bp_no_same_cycle_accept: got ready=%b busy=%b exp ready=1 busy=0", bus.in_ready, bus.busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1 || bus.round_idx !== 4'd0) $display("FAIL bp_second_accept: got busy=%b idx=%0d exp busy=1 idx=0", bus.busy, bus.round_idx); else n_pass++;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (fp_of(bus.out_data) !== expv || bus.out_valid !== 1'b1) $display("FAIL bp_second_result: got %h exp %h", fp_of(bus.out_data), expv); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midround();
        logic [63:0] key, pt, expv;
        int          n, spurious;
        use_f = 1'b1;
        key = {$urandom, $urandom};
        pt  = {$urandom, $urandom};
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_data    = ip_of(pt);
        bus.in_key     = pc1_of(key);
        bus.in_decrypt = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round_idx !== 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (bus.round_idx !== 4'd7 || bus.busy !== 1'b1) $display("FAIL mid_reach_round7: got idx=%0d busy=%b exp idx=7 busy=1", bus.round_idx, bus.busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.round_idx !== 4'd0) $display("FAIL mid_rst_round_idx: got %0d exp 0", bus.round_idx); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) spurious++;
        end
        n_checks++; if (spurious != 0) $display("FAIL mid_rst_no_output: got %0d valid cycles exp 0", spurious); else n_pass++;
        key  = {$urandom, $urandom};
        pt   = {$urandom, $urandom};
        expv = ref_des(pt, key, 1'b1);
        run_block(ip_of(pt), pc1_of(key), 1'b1);
        n_checks++; if (fp_of(rb_out) !== expv) $display("FAIL mid_rst_next_block: got %h exp %h", fp_of(rb_out), expv); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        use_f    = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_swap_path();
        test_key_schedule();
        test_des_vector();
        test_random();
        test_backpressure();
        test_reset_midround();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Iterative DES round sequencer. Accepts one 64-bit block (already through IP) and one 56-bit key (already through PC-1) per transaction, then runs 16 Feistel rounds at one round per clock.
- Holds the L/R half-block registers and the C/D key-schedule registers and applies the per-round rotations.
- Drives an external combinational f-function (expansion, subkey XOR, S-boxes, P) and returns the pre-output block for the external FP stage.

Parameters:
- ROUNDS, 16, number of rounds executed. Only 16 is legal in product builds; smaller values are for debug and use the first ROUNDS entries of the shift table.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  block/key offered
- in_ready  output  1  controller can accept a block/key
- in_data  input  64  post-IP block; L0 = [63:32], R0 = [31:0]
- in_key  input  56  post-PC-1 key; C0 = [55:28], D0 = [27:0]
- in_decrypt  input  1  1 = decrypt schedule, 0 = encrypt
- f_r  output  32  current R, fed to the external f-function
- f_cd  output  56  current {C,D}, fed to external PC-2 to form the round subkey
- f_in  input  32  f(R, K) result, combinational from f_r/f_cd
- round_idx  output  4  current round, 0..ROUNDS-1
- busy  output  1  high in ROUND state
- out_valid  output  1  pre-output block available
- out_ready  input  1  consumer accepts the block
- out_data  output  64  pre-output {R16, L16}

Behaviour:
- Reset: all of the following are 0: state = IDLE, in_ready = 1 (combinational from IDLE), out_valid, busy, round_idx, and the L, R, C, D and decrypt registers. Reset is asynchronous and takes effect mid-round or mid-DONE: the block in flight is discarded and no out_valid is produced.
- Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D each rotate independently within 28 bits.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: L <= in_data[63:32], R <= in_data[31:0], dec <= in_decrypt, round_idx <= 0, go to ROUND.
  - Encrypt load: C/D <= rotl(in_key halves, s[1]).
  - Decrypt load: C/D <= in_key unrotated, giving K16 first.
- ROUND (ROUNDS cycles, round_idx = i):
  - f_r = R, f_cd = {C,D}.
  - Each cycle: L <= R, R <= L ^ f_in.
  - When i < ROUNDS-1, also round_idx <= i+1.
  - Encrypt: C/D <= rotl(C/D, s[i+2]).
  - Decrypt: C/D <= rotr(C/D, s[ROUNDS-i]).
  - After the i = ROUNDS-1 update, go to DONE. C/D are not rotated on the last cycle.
  - busy = 1 and in_ready = 0 throughout.
- DONE:
  - out_valid = 1, out_data = {R, L} (final swap undone).
  - Registers hold while out_ready = 0; out_data must stay stable.
  - On out_valid & out_ready: go to IDLE. in_ready rises the next cycle, with no same-cycle accept.
- Latency: accept edge at cycle 0; rounds occupy cycles 1..16; out_valid is high from cycle 17. Throughput is one block per 18 cycles with out_ready held high.
- f_r and f_cd are don't-care outside ROUND but must be register outputs (no combinational path from inputs).
- For 16 rounds the total key rotation is 28, so C/D return to in_key at DONE in both modes. The verifier checks this.
- in_data, in_key and in_decrypt are ignored except at the accept edge.

Test Plan:
- f_in tied to 0, in_data = 64'h01234567_89ABCDEF, encrypt → out_data = 64'h89ABCDEF_01234567, out_valid first high 17 cycles after accept.
- in_key = {28'h0000001, 28'h0000001}, encrypt, observe f_cd per round → round0 C = D = 28'h0000002, round1 = 28'h0000004, round2 = 28'h0000010; C/D = in_key in DONE.
- Same key, decrypt → round0 C = D = 28'h0000001, round1 = 28'h8000000, round2 = 28'h2000000.
- Full-system vector with bench IP/PC-1/PC-2/FP and f-model: key 133457799BBCDFF1, plaintext 0123456789ABCDEF → ciphertext 85E813540F0AB405; decrypt of that ciphertext returns the plaintext.
- out_ready held low 5 cycles in DONE, with in_valid asserted throughout → out_data stable, in_ready = 0, no second accept until the cycle after the out handshake.
- rst_n pulsed low at round 7 → in_ready = 1, out_valid = 0, round_idx = 0 immediately. A new block accepted after reset completes correctly.
